// File: rtl/axi_read_initiator.sv
// axi_read_initiator
//   AXI4 read-channel initiator for one arbiter port. It takes a single CPU-side
//   read command, requests the bus, issues one AR transfer, and streams each R
//   beat back to the requester with data and error status. A misaligned command
//   or a stalled data phase produces a single error/last response instead.
//
// Ports
//   clk, resetn                        clock, asynchronous active-low reset
//   req_valid/req_ready                command handshake (ready only in IDLE)
//   req_addr/req_len/req_size          byte address, beats-1, log2 bytes per beat
//   bus_req/grant                      arbiter request and grant vector
//   araddr/arvalid/arready/arid/
//   arlen/arsize/arburst               AXI AR channel (registered, INCR, constant id)
//   rvalid/rready/rdata/rresp/
//   rlast/rid                          AXI R channel
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_err/rsp_last                   per-beat response to the requester
module axi_read_initiator #(
    parameter int MASTER_IDX      = 0,
    parameter int MAX_BEATS       = 8,
    parameter int TIMEOUT         = 255,
    parameter int ID              = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int ALEN            = 8,
    parameter int ASIZE           = 3,
    parameter int ABURST          = 2,
    parameter int ID_WIDTH        = 4,
    parameter int ACERR_WIDTH     = 2,
    parameter int NUM_ARB_MASTERS = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DATA_WIDTH-1:0]      req_addr,
    input  logic [ALEN-1:0]            req_len,
    input  logic [ASIZE-1:0]           req_size,
    output logic                       bus_req,
    input  logic [NUM_ARB_MASTERS-1:0] grant,
    output logic [DATA_WIDTH-1:0]      araddr,
    output logic                       arvalid,
    input  logic                       arready,
    output logic [ID_WIDTH-1:0]        arid,
    output logic [ALEN-1:0]            arlen,
    output logic [ASIZE-1:0]           arsize,
    output logic [ABURST-1:0]          arburst,
    input  logic                       rvalid,
    output logic                       rready,
    input  logic [DATA_WIDTH-1:0]      rdata,
    input  logic [ACERR_WIDTH-1:0]     rresp,
    input  logic                       rlast,
    input  logic [ID_WIDTH-1:0]        rid,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       rsp_err,
    output logic                       rsp_last
);

    localparam logic [ALEN-1:0]            LEN_MAX   = ALEN'(MAX_BEATS - 1);
    localparam logic [ID_WIDTH-1:0]        ID_V      = ID_WIDTH'(ID);
    localparam logic [NUM_ARB_MASTERS-1:0] GRANT_SEL = NUM_ARB_MASTERS'(1) << MASTER_IDX;
    // Top bit of RRESP marks SLVERR/DECERR.
    localparam logic [ACERR_WIDTH-1:0]     RESP_ERR  = ACERR_WIDTH'(1) << (ACERR_WIDTH - 1);
    localparam logic [15:0]                TO_LIMIT  = 16'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, ERR} state_t;

    state_t                state;
    logic [ALEN-1:0]       beat_cnt;
    logic [15:0]           to_cnt;
    logic [DATA_WIDTH-1:0] align_mask;
    logic                  misaligned;
    logic                  granted;
    logic                  cnt_last;
    logic                  beat;
    logic                  timeout_hit;

    assign arid    = ID_V;
    assign arburst = ABURST'(1);

    always_comb begin
        align_mask  = ~({DATA_WIDTH{1'b1}} << req_size);
        misaligned  = |(req_addr & align_mask);
        granted     = |(grant & GRANT_SEL);
        cnt_last    = (beat_cnt == arlen);
        beat        = (state == DATA) && rvalid && rsp_ready;
        timeout_hit = (TIMEOUT != 0) && !rvalid && ((to_cnt + 16'd1) == TO_LIMIT);
        req_ready   = (state == IDLE);

        rready    = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        rsp_last  = 1'b0;
        case (state)
            DATA: begin
                rready    = rsp_ready;
                rsp_valid = rvalid;
                rsp_data  = rdata;
                rsp_last  = cnt_last;
                // A missing or early rlast is reported as an error on that beat.
                rsp_err   = (|(rresp & RESP_ERR)) || (rid != ID_V) || (rlast != cnt_last);
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                rsp_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            arvalid  <= 1'b0;
            araddr   <= '0;
            arlen    <= '0;
            arsize   <= '0;
            beat_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        araddr <= req_addr;
                        arlen  <= (req_len > LEN_MAX) ? LEN_MAX : req_len;
                        arsize <= req_size;
                        if (misaligned) begin
                            state <= ERR;
                        end else begin
                            state   <= ARB;
                            bus_req <= 1'b1;
                        end
                    end
                end
                ARB: begin
                    if (granted) begin
                        state   <= ADDR;
                        arvalid <= 1'b1;
                    end
                end
                ADDR: begin
                    // arvalid is held regardless of grant until the handshake.
                    if (arready) begin
                        state    <= DATA;
                        arvalid  <= 1'b0;
                        beat_cnt <= '0;
                        to_cnt   <= '0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        to_cnt <= '0;
                        if (cnt_last || rlast) begin
                            state   <= IDLE;
                            bus_req <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + ALEN'(1);
                        end
                    end else if (timeout_hit) begin
                        state   <= ERR;
                        bus_req <= 1'b0;
                    end else if (!rvalid) begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ERR: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_initiator.sv
module tb_axi_read_initiator;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [2:0]  req_size = '0;
    logic        bus_req;
    logic [1:0]  grant = '0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic [3:0]  rid = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_last;

    axi_read_initiator #(
        .MASTER_IDX(0), .MAX_BEATS(8), .TIMEOUT(8), .ID(0)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size),
        .bus_req(bus_req), .grant(grant),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_last(rsp_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
        logic        l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got data %h err %b last %b expected none",
                         rsp_data, rsp_err, rsp_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.d);
                check("rsp_err", 32'(rsp_err), 32'(e.e));
                check("rsp_last", 32'(rsp_last), 32'(e.l));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        req_size  = size;
        step();
        req_valid = 1'b0;
    endtask

    // Command through AR with immediate grant and arready.
    task automatic bring_up(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] exp_len);
        issue(addr, len, 3'd2);
        check("bus_req_arb", 32'(bus_req), 32'd1);
        grant = 2'b01;
        step();
        grant = 2'b00;
        check("arvalid_after_grant", 32'(arvalid), 32'd1);
        check("araddr", araddr, addr);
        check("arlen", 32'(arlen), 32'(exp_len));
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("arvalid_drop", 32'(arvalid), 32'd0);
    endtask

    task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] exp_len,
                            input int nbeats, input int err_beat, input int rlast_at, input bit toggle);
        bit   tog;
        exp_t e;
        bring_up(addr, len, exp_len);
        tog = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            rvalid = 1'b1;
            rdata  = {addr[15:0], 16'(i)} ^ 32'hA5A5_0000;
            rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            rlast  = (i == rlast_at);
            e.d = rdata;
            e.l = (i == int'(exp_len));
            e.e = (i == err_beat) || (rlast != e.l);
            sb.push_back(e);
            if (i == 0) check("bus_req_data", 32'(bus_req), 32'd1);
            for (int k = 0; k < 4; k++) begin
                rsp_ready = toggle ? tog : 1'b1;
                tog = ~tog;
                #1;
                check("rready_mirror", 32'(rready), 32'(rsp_ready));
                step();
                if (rsp_ready) break;
            end
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rsp_ready = 1'b0;
        check("bus_req_done", 32'(bus_req), 32'd0);
        check("req_ready_done", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t e;
        // Reset state
        #12;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_arburst", 32'(arburst), 32'd1);
        check("rst_arid", 32'(arid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // 1: single read with delayed grant and arready
        issue(32'h0200_BFF8, 8'd0, 3'd2);
        check("t1_bus_req", 32'(bus_req), 32'd1);
        check("t1_arvalid_arb", 32'(arvalid), 32'd0);
        step();
        check("t1_arvalid_arb2", 32'(arvalid), 32'd0);
        grant = 2'b01;
        step();
        grant = 2'b00;
        check("t1_arvalid", 32'(arvalid), 32'd1);
        check("t1_araddr", araddr, 32'h0200_BFF8);
        check("t1_arsize", 32'(arsize), 32'd2);
        step();
        check("t1_arvalid_hold", 32'(arvalid), 32'd1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("t1_arvalid_drop", 32'(arvalid), 32'd0);
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00; rlast = 1'b1; rsp_ready = 1'b1;
        e.d = 32'h1234_5678; e.e = 1'b0; e.l = 1'b1;
        sb.push_back(e);
        step();
        rvalid = 1'b0; rlast = 1'b0; rsp_ready = 1'b0;
        check("t1_bus_req_done", 32'(bus_req), 32'd0);
        check("t1_req_ready", 32'(req_ready), 32'd1);

        // 2: burst of 4 with toggling rsp_ready
        do_burst(32'h0000_1000, 8'd3, 8'd3, 4, -1, 3, 1'b1);
        // 3: SLVERR on beat 2
        do_burst(32'h0000_2000, 8'd3, 8'd3, 4, 1, 3, 1'b0);
        // length clamp: 20 -> 7
        do_burst(32'h0000_3000, 8'd20, 8'd7, 8, -1, 7, 1'b0);
        // early rlast on beat 3 of 4 ends the command with an error
        do_burst(32'h0000_4000, 8'd3, 8'd3, 3, -1, 2, 1'b0);

        // 4: timeout with no R beats
        bring_up(32'h0000_0100, 8'd0, 8'd0);
        rsp_ready = 1'b1;
        e.d = 32'd0; e.e = 1'b1; e.l = 1'b1;
        sb.push_back(e);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (rsp_valid) begin
                n = k;
                break;
            end
        end
        check("t4_timeout_cycles", 32'(n), 32'd8);
        step();
        rsp_ready = 1'b0;
        check("t4_req_ready", 32'(req_ready), 32'd1);
        check("t4_bus_req", 32'(bus_req), 32'd0);

        // 5: misaligned command
        e.d = 32'd0; e.e = 1'b1; e.l = 1'b1;
        sb.push_back(e);
        issue(32'h8000_0002, 8'd0, 3'd2);
        check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t5_bus_req", 32'(bus_req), 32'd0);
        check("t5_arvalid", 32'(arvalid), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t5_req_ready", 32'(req_ready), 32'd1);
        check("t5_bus_req_after", 32'(bus_req), 32'd0);

        // 6: reset while in ADDR
        issue(32'h0000_0600, 8'd0, 3'd2);
        grant = 2'b01;
        step();
        grant = 2'b00;
        check("t6_arvalid_pre", 32'(arvalid), 32'd1);
        resetn = 1'b0;
        #1;
        check("t6_arvalid_rst", 32'(arvalid), 32'd0);
        check("t6_bus_req_rst", 32'(bus_req), 32'd0);
        check("t6_rready_rst", 32'(rready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        do_burst(32'h0000_5000, 8'd0, 8'd0, 1, -1, 0, 1'b0);

        step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
